// File: rtl/branch_hazard_ctrl.sv
// Decode-stage hazard controller: branch/load stalls, taken-branch flush, D-stage Rs forwarding, HALT freeze.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module branch_hazard_ctrl #(
    parameter logic [2:0]  RET_REG = 3'h7,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      Instruction_IFID,
    input  logic             DReadsRs,
    input  logic             DReadsRt,
    input  logic             DIsBranch,
    input  logic             BranchTaken_D,
    input  logic             DIsHalt,
    input  logic             RegWriteEnable_IDEX,
    input  logic             MemRead_IDEX,
    input  logic [1:0]       WriteRegSel_IDEX,
    input  logic [15:0]      Instruction_IDEX,
    input  logic             RegWriteEnable_EXMEM,
    input  logic             MemRead_EXMEM,
    input  logic [1:0]       WriteRegSel_EXMEM,
    input  logic [15:0]      Instruction_EXMEM,
    output logic             Stall_PC_IFID,
    output logic             Bubble_IDEX,
    output logic             Flush_IFID,
    output logic [1:0]       ForwardSel_D,
    output logic             Halted,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);
    // state  | meaning
    // RUN    | hazards evaluated every cycle
    // STALL  | second cycle of a branch-after-load stall, inputs ignored
    // HALTED | HALT retired into D, pipeline frozen until reset
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, HALTED = 2'd2} state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       wb_hit_q, wb_hit_d;

    logic [2:0] rs, rt, ex_dst, mem_dst;
    logic       ex_hit_rs, ex_hit_rt, mem_hit_rs;
    logic [1:0] need;
    logic       stall;
    logic       unused_bits;

    function automatic logic [2:0] dest_reg(input logic [1:0] sel, input logic [15:0] instr);
        case (sel)
            2'b00:   dest_reg = instr[7:5];
            2'b01:   dest_reg = instr[4:2];
            2'b10:   dest_reg = instr[10:8];
            default: dest_reg = RET_REG;
        endcase
    endfunction

    assign rs      = Instruction_IFID[10:8];
    assign rt      = Instruction_IFID[7:5];
    assign ex_dst  = dest_reg(WriteRegSel_IDEX, Instruction_IDEX);
    assign mem_dst = dest_reg(WriteRegSel_EXMEM, Instruction_EXMEM);

    assign ex_hit_rs  = RegWriteEnable_IDEX  && (ex_dst == rs);
    assign ex_hit_rt  = RegWriteEnable_IDEX  && (ex_dst == rt);
    assign mem_hit_rs = RegWriteEnable_EXMEM && (mem_dst == rs);

    assign unused_bits = ^{Instruction_IFID[15:11], Instruction_IFID[4:0],
                           Instruction_IDEX[15:11], Instruction_IDEX[1:0],
                           Instruction_EXMEM[15:11], Instruction_EXMEM[1:0]};

    // Branches resolve in D, so they also wait on ALU results and on MEM-stage loads.
    always_comb begin
        need = 2'd0;
        if (DIsBranch) begin
            if (ex_hit_rs)
                need = MemRead_IDEX ? 2'd2 : 2'd1;
            else if (mem_hit_rs && MemRead_EXMEM)
                need = 2'd1;
        end else if (MemRead_IDEX && ((DReadsRs && ex_hit_rs) || (DReadsRt && ex_hit_rt))) begin
            need = 2'd1;
        end
    end

    assign stall = rst_n && ((state_q != RUN) || (need != 2'd0));

    assign Stall_PC_IFID = stall;
    assign Bubble_IDEX   = stall;
    assign Flush_IFID    = rst_n && DIsBranch && BranchTaken_D && !stall && (state_q != HALTED);
    assign Halted        = (state_q == HALTED);

    always_comb begin
        ForwardSel_D = 2'b00;
        if (rst_n) begin
            if (mem_hit_rs && !MemRead_EXMEM)
                ForwardSel_D = 2'b01;
            else if (wb_hit_q)
                ForwardSel_D = 2'b10;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wb_hit_d = mem_hit_rs && MemRead_EXMEM;
        case (state_q)
            RUN: begin
                if (need == 2'd2) begin
                    state_d = STALL;
                    cnt_d   = 2'd0;
                end else if (need == 2'd0 && DIsHalt) begin
                    state_d = HALTED;
                end
            end
            STALL: begin
                if (cnt_q == 2'd0)
                    state_d = RUN;
                else
                    cnt_d = cnt_q - 2'd1;
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            cnt_q    <= 2'd0;
            wb_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wb_hit_q <= wb_hit_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (state_q != HALTED) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (Flush_IFID && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: single-cycle vector table plus multi-cycle sequences.
module tb_branch_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] Instruction_IFID, Instruction_IDEX, Instruction_EXMEM;
    logic        DReadsRs, DReadsRt, DIsBranch, BranchTaken_D, DIsHalt;
    logic        RegWriteEnable_IDEX, MemRead_IDEX, RegWriteEnable_EXMEM, MemRead_EXMEM;
    logic [1:0]  WriteRegSel_IDEX, WriteRegSel_EXMEM;
    logic        Stall_PC_IFID, Bubble_IDEX, Flush_IFID, Halted;
    logic [1:0]  ForwardSel_D;
    logic [15:0] StallCount, FlushCount;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .Instruction_IFID(Instruction_IFID), .DReadsRs(DReadsRs), .DReadsRt(DReadsRt),
        .DIsBranch(DIsBranch), .BranchTaken_D(BranchTaken_D), .DIsHalt(DIsHalt),
        .RegWriteEnable_IDEX(RegWriteEnable_IDEX), .MemRead_IDEX(MemRead_IDEX),
        .WriteRegSel_IDEX(WriteRegSel_IDEX), .Instruction_IDEX(Instruction_IDEX),
        .RegWriteEnable_EXMEM(RegWriteEnable_EXMEM), .MemRead_EXMEM(MemRead_EXMEM),
        .WriteRegSel_EXMEM(WriteRegSel_EXMEM), .Instruction_EXMEM(Instruction_EXMEM),
        .Stall_PC_IFID(Stall_PC_IFID), .Bubble_IDEX(Bubble_IDEX), .Flush_IFID(Flush_IFID),
        .ForwardSel_D(ForwardSel_D), .Halted(Halted),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    typedef struct {
        string       name;
        logic        br, tk, rdrs, rdrt, halt;
        logic [15:0] ifid;
        logic        ex_we, ex_mr;
        logic [1:0]  ex_sel;
        logic [15:0] ex_ins;
        logic        mem_we, mem_mr;
        logic [1:0]  mem_sel;
        logic [15:0] mem_ins;
        logic        e_stall, e_flush;
        logic [1:0]  e_fwd;
    } vec_t;

    vec_t vecs[16];

    // Instruction with fields [10:8]=a, [7:5]=b, [4:2]=c.
    function automatic logic [15:0] ins(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        ins = {5'b0, a, b, c, 2'b0};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic e_stall, input logic e_flush,
                           input logic [1:0] e_fwd, input logic e_halted);
        chk({nm, ".stall"},  {15'b0, Stall_PC_IFID}, {15'b0, e_stall});
        chk({nm, ".bubble"}, {15'b0, Bubble_IDEX},   {15'b0, e_stall});
        chk({nm, ".flush"},  {15'b0, Flush_IFID},    {15'b0, e_flush});
        chk({nm, ".fwd"},    {14'b0, ForwardSel_D},  {14'b0, e_fwd});
        chk({nm, ".halted"}, {15'b0, Halted},        {15'b0, e_halted});
    endtask

    task automatic drive(input vec_t v);
        DIsBranch = v.br; BranchTaken_D = v.tk; DReadsRs = v.rdrs; DReadsRt = v.rdrt;
        DIsHalt = v.halt; Instruction_IFID = v.ifid;
        RegWriteEnable_IDEX = v.ex_we; MemRead_IDEX = v.ex_mr;
        WriteRegSel_IDEX = v.ex_sel; Instruction_IDEX = v.ex_ins;
        RegWriteEnable_EXMEM = v.mem_we; MemRead_EXMEM = v.mem_mr;
        WriteRegSel_EXMEM = v.mem_sel; Instruction_EXMEM = v.mem_ins;
    endtask

    task automatic neutral();
        vec_t v;
        v = vecs[0];
        drive(v);
    endtask

    // Async reset pulse inside the low clock phase; leaves the bench just after a negedge.
    task automatic rst_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        logic [15:0] e_sc, e_fc;

        //          name                 br tk rs rt h  ifid         we mr sel    ex_ins       we mr sel    mem_ins      st fl fwd
        vecs[0]  = '{"idle",             0, 0, 0, 0, 0, ins(1,2,0),  0, 0, 2'b00, ins(0,0,0),  0, 0, 2'b00, ins(0,0,0),  0, 0, 2'b00};
        vecs[1]  = '{"br_ex_alu",        1, 1, 1, 0, 0, ins(3,0,0),  1, 0, 2'b00, ins(0,3,0),  0, 0, 2'b00, ins(0,0,0),  1, 0, 2'b00};
        vecs[2]  = '{"br_ex_load",       1, 1, 1, 0, 0, ins(3,0,0),  1, 1, 2'b00, ins(0,3,0),  0, 0, 2'b00, ins(0,0,0),  1, 0, 2'b00};
        vecs[3]  = '{"br_mem_load",      1, 0, 1, 0, 0, ins(3,0,0),  0, 0, 2'b00, ins(0,0,0),  1, 1, 2'b00, ins(0,3,0),  1, 0, 2'b00};
        vecs[4]  = '{"br_mem_alu",       1, 1, 1, 0, 0, ins(3,0,0),  0, 0, 2'b00, ins(0,0,0),  1, 0, 2'b01, ins(0,0,3),  0, 1, 2'b01};
        vecs[5]  = '{"alu_rt_ex_load",   0, 0, 1, 1, 0, ins(1,5,0),  1, 1, 2'b01, ins(0,0,5),  0, 0, 2'b00, ins(0,0,0),  1, 0, 2'b00};
        vecs[6]  = '{"alu_rt_unread",    0, 0, 1, 0, 0, ins(1,5,0),  1, 1, 2'b01, ins(0,0,5),  0, 0, 2'b00, ins(0,0,0),  0, 0, 2'b00};
        vecs[7]  = '{"alu_rs_ex_alu",    0, 0, 1, 1, 0, ins(4,1,0),  1, 0, 2'b10, ins(4,0,0),  0, 0, 2'b00, ins(0,0,0),  0, 0, 2'b00};
        vecs[8]  = '{"jr_r7_jal",        1, 1, 1, 0, 0, ins(7,0,0),  1, 0, 2'b11, ins(0,0,0),  0, 0, 2'b00, ins(0,0,0),  1, 0, 2'b00};
        vecs[9]  = '{"br_taken_unrel",   1, 1, 1, 0, 0, ins(2,0,0),  1, 0, 2'b00, ins(0,3,0),  0, 0, 2'b00, ins(0,0,0),  0, 1, 2'b00};
        vecs[10] = '{"ex_we_off",        1, 0, 1, 0, 0, ins(3,0,0),  0, 1, 2'b00, ins(0,3,0),  0, 0, 2'b00, ins(0,0,0),  0, 0, 2'b00};
        vecs[11] = '{"r0_match",         1, 0, 1, 0, 0, ins(0,1,0),  1, 0, 2'b10, ins(0,2,0),  0, 0, 2'b00, ins(0,0,0),  1, 0, 2'b00};
        vecs[12] = '{"alu_mem_load",     0, 0, 1, 0, 0, ins(3,0,0),  0, 0, 2'b00, ins(0,0,0),  1, 1, 2'b00, ins(0,3,0),  0, 0, 2'b00};
        vecs[13] = '{"halt_only",        0, 0, 0, 0, 1, ins(1,2,0),  0, 0, 2'b00, ins(0,0,0),  0, 0, 2'b00, ins(0,0,0),  0, 0, 2'b00};
        vecs[14] = '{"mem_alu_rt_only",  0, 0, 1, 1, 0, ins(1,6,0),  0, 0, 2'b00, ins(0,0,0),  1, 0, 2'b00, ins(0,6,0),  0, 0, 2'b00};
        vecs[15] = '{"ret_sel_nomatch",  1, 0, 1, 0, 0, ins(6,0,0),  1, 0, 2'b11, ins(6,6,6),  0, 0, 2'b00, ins(0,0,0),  0, 0, 2'b00};

        rst_n = 1'b0;
        neutral();
        repeat (2) @(negedge clk);

        // Outputs must be quiet under reset even with hazards and forwarding hits present.
        drive(vecs[1]);
        #1;
        chk_out("reset_ex_hazard", 0, 0, 2'b00, 0);
        drive(vecs[4]);
        #1;
        chk_out("reset_mem_alu", 0, 0, 2'b00, 0);
        chk("reset_stallcnt", StallCount, 16'h0);
        chk("reset_flushcnt", FlushCount, 16'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            rst_pulse();
            drive(vecs[i]);
            #1;
            chk_out(vecs[i].name, vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_fwd, 1'b0);
        end

        // A: branch after ALU producer, one stall then MEM->D forward.
        rst_pulse();
        v = vecs[1]; v.tk = 1'b0; drive(v); #1;
        chk_out("seqA.c0", 1, 0, 2'b00, 0);
        step();
        v.ex_we = 1'b0; v.mem_we = 1'b1; v.mem_mr = 1'b0; v.mem_sel = 2'b00; v.mem_ins = ins(0,3,0);
        drive(v); #1;
        chk_out("seqA.c1", 0, 0, 2'b01, 0);

        // B: branch after load, two stalls, then WB forward and flush.
        step();
        v = vecs[2]; drive(v); #1;
        chk_out("seqB.c0", 1, 0, 2'b00, 0);
        step();
        v.ex_we = 1'b0; v.ex_mr = 1'b0; v.mem_we = 1'b1; v.mem_mr = 1'b1; v.mem_sel = 2'b00; v.mem_ins = ins(0,3,0);
        drive(v); #1;
        chk_out("seqB.c1", 1, 0, 2'b00, 0);
        chk("seqB.c1.state", {14'b0, dut.state_q}, 16'd1);
        step();
        v.mem_we = 1'b0; v.mem_mr = 1'b0;
        drive(v); #1;
        chk_out("seqB.c2", 0, 1, 2'b10, 0);
        step();
        neutral(); #1;
        chk_out("seqB.c3", 0, 0, 2'b00, 0);
`ifdef HAZARD_PERF_CNT_EN
        e_sc = 16'd3; e_fc = 16'd1;
`else
        e_sc = 16'd0; e_fc = 16'd0;
`endif
        chk("perf_stallcnt", StallCount, e_sc);
        chk("perf_flushcnt", FlushCount, e_fc);

        // C: STALL state ignores inputs even after the hazard has vanished.
        rst_pulse();
        drive(vecs[2]); #1;
        chk_out("seqC.c0", 1, 0, 2'b00, 0);
        step();
        drive(vecs[9]); #1;
        chk_out("seqC.c1", 1, 0, 2'b00, 0);
        step();
        #1;
        chk_out("seqC.c2", 0, 1, 2'b00, 0);

        // D: HALT freezes, reset releases.
        rst_pulse();
        drive(vecs[13]); #1;
        chk_out("seqD.c0", 0, 0, 2'b00, 0);
        step();
        drive(vecs[9]); #1;
        chk_out("seqD.c1", 1, 0, 2'b00, 1);
        repeat (5) step();
        neutral(); #1;
        chk_out("seqD.c6", 1, 0, 2'b00, 1);
        rst_n = 1'b0;
        drive(vecs[4]); #1;
        chk_out("seqD.rst", 0, 0, 2'b00, 0);
        rst_n = 1'b1;
        neutral(); #1;
        chk_out("seqD.after", 0, 0, 2'b00, 0);
        chk("seqD.state", {14'b0, dut.state_q}, 16'd0);

        // E: stall wins over simultaneous HALT; HALT taken once stall clears.
        rst_pulse();
        v = vecs[1]; v.halt = 1'b1; v.tk = 1'b0; drive(v); #1;
        chk_out("seqE.c0", 1, 0, 2'b00, 0);
        step();
        v.ex_we = 1'b0; drive(v); #1;
        chk_out("seqE.c1", 0, 0, 2'b00, 0);
        step();
        neutral(); #1;
        chk_out("seqE.c2", 1, 0, 2'b00, 1);

        // F: reset in the middle of STALL leaves no pending stall.
        rst_pulse();
        drive(vecs[2]); #1;
        step();
        neutral(); #1;
        chk_out("seqF.in_stall", 1, 0, 2'b00, 0);
        rst_n = 1'b0; #1; rst_n = 1'b1; #1;
        chk_out("seqF.after_rst", 0, 0, 2'b00, 0);

`ifdef HAZARD_PERF_CNT_EN
        rst_pulse();
        drive(vecs[1]);
        repeat (65540) @(posedge clk);
        @(negedge clk); #1;
        chk("perf_stall_sat", StallCount, 16'hFFFF);
        chk("perf_flush_sat", FlushCount, 16'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
